sig_sched: RTL and testbench

SIG_SCHED -- requirements
Module: sig_sched

---
 rtl/sig_pkg.sv | 15 +
 rtl/sig_rsp_fifo.sv | 51 +++++
 rtl/sig_sched.sv | 105 ++++++++++
 tb/tb_sig_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// sig_pkg: shared defaults and types for the sigmoid-engine scheduler.
//   SIG_W / SIG_NREQ / SIG_LAT : default data width, requester count, engine latency
//   tag_t                      : {valid, id} entry of the tag pipe shadowing the engine
package sig_pkg;
  localparam int SIG_W    = 20;
  localparam int SIG_NREQ = 4;
  localparam int SIG_LAT  = 3;
  // Fixed-width id field so the type stays parameter-free; users take the low IDW bits.
  localparam int TAG_IDW  = 8;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;
endpackage

// File: rtl/sig_rsp_fifo.sv
// sig_rsp_fifo: result FIFO holding {id, y} entries between the engine and the consumer.
//   clk, rst_n      : clock, synchronous active-low reset (empties the FIFO)
//   wr_en, wr_data  : push port (caller guarantees no overflow)
//   rd_en           : pop of the head entry (caller guarantees not empty)
//   rd_data         : head entry, reads 0 while empty
//   empty, count    : occupancy status
module sig_rsp_fifo #(
  parameter int DEPTH = 5,
  parameter int DW    = 22,
  localparam int CW   = $clog2(DEPTH+1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= inc(wr_ptr);
      if (rd_en) rd_ptr <= inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/sig_sched.sv
// sig_sched: round-robin scheduler sharing one fixed-latency, non-stalling sigmoid
// engine among NREQ requesters, with a credit-controlled in-order result FIFO.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_x     : per-requester request valid and packed operands
//   req_ready           : one-hot accept
//   eng_valid/eng_x     : issue strobe and operand to the engine
//   eng_y               : engine result, LAT cycles after eng_valid
//   rsp_valid/rsp_ready : response handshake; rsp_y/rsp_id carry result and owner
//   stall_cnt           : saturating stall counter (only with SIG_SCHED_STATS_EN)
module sig_sched import sig_pkg::*; #(
  parameter int NREQ   = SIG_NREQ,
  parameter int W      = SIG_W,
  parameter int LAT    = SIG_LAT,
  localparam int DEPTH = LAT + 2,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic              eng_valid,
  output logic [W-1:0]      eng_x,
  input  logic [W-1:0]      eng_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_y,
  output logic [IDW-1:0]    rsp_id
`ifdef SIG_SCHED_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH+1);

  tag_t           tag_pipe [LAT];
  logic [IDW-1:0] ptr, gnt;
  logic           found, credit, issue, pop, fifo_empty;
  logic [CW-1:0]  fifo_count;
  int             inflight;

  // Round-robin search starting at ptr.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        gnt   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    inflight = 0;
    for (int s = 0; s < LAT; s++) inflight += int'(tag_pipe[s].valid);
  end

  // Every issued op reserves a FIFO slot now; a same-cycle pop frees one,
  // which lets issue resume in the very cycle backpressure is released.
  assign pop       = rsp_valid && rsp_ready;
  assign credit    = (int'(fifo_count) + inflight - int'(pop)) < DEPTH;
  assign issue     = rst_n && found && credit;
  assign req_ready = issue ? (NREQ'(1) << gnt) : '0;
  assign eng_valid = issue;
  assign eng_x     = req_x[int'(gnt)*W +: W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      for (int s = 0; s < LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0].valid <= issue;
      tag_pipe[0].id    <= TAG_IDW'(gnt);
      for (int s = 1; s < LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      if (issue) ptr <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);
    end
  end

  // Upper id bits of the fixed-width tag are never populated.
  logic unused_tag_bits;
  assign unused_tag_bits = ^tag_pipe[LAT-1].id;

  sig_rsp_fifo #(.DEPTH(DEPTH), .DW(W+IDW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tag_pipe[LAT-1].valid),
    .wr_data ({tag_pipe[LAT-1].id[IDW-1:0], eng_y}),
    .rd_en   (pop),
    .rd_data ({rsp_id, rsp_y}),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rsp_valid = !fifo_empty;

`ifdef SIG_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (|req_valid && !issue && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sig_sched.sv
// tb_sig_sched: directed bench for sig_sched with a scoreboard queue and an
// independent response monitor. Engine model: eng_y = ~eng_x, LAT cycles later.
module tb_sig_sched;
  localparam int NREQ = 4, W = 20, LAT = 3, IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ-1:0]   req_ready;
  logic              eng_valid;
  logic [W-1:0]      eng_x, eng_y;
  logic              rsp_valid, rsp_ready;
  logic [W-1:0]      rsp_y;
  logic [IDW-1:0]    rsp_id;
`ifdef SIG_SCHED_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  sig_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .eng_valid(eng_valid), .eng_x(eng_x), .eng_y(eng_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id)
`ifdef SIG_SCHED_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] eng_pipe [LAT];
  always @(posedge clk) begin
    eng_pipe[0] <= ~eng_x;
    for (int s = 1; s < LAT; s++) eng_pipe[s] <= eng_pipe[s-1];
  end
  assign eng_y = eng_pipe[LAT-1];

  logic [W-1:0] xs [NREQ] = '{20'h00010, 20'h12345, 20'h0ABCD, 20'h55555};
  logic [W-1:0] ys [NREQ] = '{20'hFFFEF, 20'hEDCBA, 20'hF5432, 20'hAAAAA};

  int n_cmp = 0, n_bad = 0;
  logic [IDW+W-1:0] sb [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted response is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_y), 32'hDEAD);
      end else begin
        logic [IDW+W-1:0] e;
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e[IDW+W-1:W]));
        check("rsp_y",  32'(rsp_y),  32'(e[W-1:0]));
      end
    end
  end

  task automatic next;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = '0;
    next();
    rst_n = 1'b1;
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); n++;
    end
    #1;
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_x = {xs[3], xs[2], xs[1], xs[0]};
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1;
    next(); next();
    // Reset state, with requests pending during reset.
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_eng_valid", 32'(eng_valid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_y",     32'(rsp_y),     32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
`ifdef SIG_SCHED_STATS_EN
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    next();
    rst_n = 1'b1; req_valid = '0;

    // Single request and latency.
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_eng_valid", 32'(eng_valid), 32'd1);
    check("t1_req_ready", 32'(req_ready), 32'b0001);
    check("t1_eng_x",     32'(eng_x),     32'h00010);
    sb.push_back({2'd0, 20'hFFFEF});
    next();
    req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t1_rsp_valid_c%0d", c), 32'(rsp_valid), (c == 4) ? 32'd1 : 32'd0);
      next();
    end
    drain();

    // Round-robin, one issue per cycle.
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t2_req_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      check($sformatf("t2_eng_x_%0d", k), 32'(eng_x), 32'(xs[k % 4]));
      sb.push_back({2'(k % 4), ys[k % 4]});
      next();
    end
    req_valid = '0;
    drain();

    // Backpressure: exactly DEPTH issues, then stall with a stable head.
    do_reset();
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t3_issue_%0d", k), 32'({eng_valid, req_ready}), 32'({1'b1, 4'(1 << (k % 4))}));
      sb.push_back({2'(k % 4), ys[k % 4]});
      next();
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("t3_stall_%0d", k), 32'({eng_valid, req_ready}), 32'd0);
      if (k >= 4) begin
        check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t3_rsp_head",  32'({rsp_id, rsp_y}), 32'({2'd0, 20'hFFFEF}));
      end
      next();
    end

    // Release: issue resumes in the same cycle as the first pop.
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_eng_valid", 32'(eng_valid), 32'd1);
    check("t4_req_ready", 32'(req_ready), 32'b0010);
`ifdef SIG_SCHED_STATS_EN
    check("t4_stall_cnt", 32'(stall_cnt), 32'd10);
`endif
    sb.push_back({2'd1, ys[1]});
    next();
    req_valid = '0;
    drain();

    // Reset mid-flight: in-flight results are discarded, ptr returns to 0.
    do_reset();
    req_valid = 4'b0011;
    @(negedge clk);
    check("t5_gnt0", 32'(req_ready), 32'b0001);
    next();
    @(negedge clk);
    check("t5_gnt1", 32'(req_ready), 32'b0010);
    next();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_issue", 32'({eng_valid, req_ready}), 32'd0);
    next();
    rst_n = 1'b1; req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("t5_no_rsp_%0d", c), 32'(rsp_valid), 32'd0);
      next();
    end
    req_valid = 4'b0110;
    @(negedge clk);
    check("t5_post_gnt", 32'({eng_valid, req_ready}), 32'({1'b1, 4'b0010}));
    sb.push_back({2'd1, ys[1]});
    next();
    req_valid = '0;
    drain();

`ifdef SIG_SCHED_STATS_EN
    // Saturation of the stall counter.
    do_reset();
    rsp_ready = 1'b0; req_valid = 4'hF;
    repeat (70010) @(posedge clk);
    #1;
    check("stall_sat", 32'(stall_cnt), 32'hFFFF);
    do_reset();
    rsp_ready = 1'b1;
`endif

    next();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
